instr_fetch_responder: RTL
==========================

// Module: instr_fetch_responder
// PURPOSE
//  Responder (memory side) of the Ibex instruction-fetch req/gnt/rvalid interface. It replaces the
//  hardwired gnt/rvalid glue in the compliance top. Grants fetches under an outstanding-request
//  limit and drives the read-only port of the shared RAM. Returns rdata/err in order, a fixed
//  RespLatency cycles after grant. Unmapped or misaligned fetches get a bus error.
// PARAMETERS
//  BaseAddr        32'h0000_0000  byte base of the fetchable window
//  SizeBytes       2*1024*1024    window size; power of 2
//  RespLatency     1              cycles from gnt to rvalid; >=1 (1 = raw RAM latency)
//  MaxOutstanding  2              max granted-but-unanswered fetches; 1..RespLatency+1
//  StallSeed       16'hACE1       nonzero LFSR seed (used only with IFR_STALL_EN)
// PORTS
//  clk_sys_i       in   1   system clock
//  rst_sys_ni      in   1   async reset, active low
//  instr_req_i     in   1   core fetch request
//  instr_addr_i    in   32  fetch byte address; held stable by the core while req & ~gnt
//  instr_gnt_o     out  1   request accepted this cycle
//  instr_rvalid_o  out  1   response valid; the core cannot backpressure it
//  instr_rdata_o   out  32  fetched word; 0 when err
//  instr_err_o     out  1   bus error, qualified by rvalid
//  mem_req_o       out  1   RAM read-port request
//  mem_addr_o      out  32  RAM byte address (= instr_addr_i)
//  mem_rdata_i     in   32  RAM read data, valid the cycle after mem_req_o
//  busy_o          out  1   outstanding count != 0
// BEHAVIOUR
//  - Reset values:
//    - all outputs 0; outstanding count 0; response pipeline cleared.
//    - Reset mid-operation discards in-flight responses; no rvalid follows reset release.
//  - Acceptance: gnt = req & ~stall & (cnt_q < MaxOutstanding | instr_rvalid_o).
//    A response retiring in the same cycle frees its slot.
//  - Error decode (combinational, at grant): err = addr[1:0]!=0 | (addr & ~(SizeBytes-1)) != BaseAddr.
//  - mem_req_o = gnt & ~err, in the same cycle as gnt. Error fetches never touch the RAM.
//  - Pipeline: shift register of RespLatency entries {valid, err}, with a data field in entries 2..RespLatency.
//    - Entry 1 takes {gnt, err} at grant.
//    - Data enters the pipeline from mem_rdata_i one cycle after grant.
//    - RespLatency=1: rvalid is the registered gnt; rdata = err ? 0 : mem_rdata_i (no data flop).
//    - rvalid_o asserts exactly RespLatency cycles after its gnt; responses stay strictly in order.
//  - Counter width $clog2(MaxOutstanding+1):
//    - +1 on gnt only; -1 on rvalid only; unchanged on both or neither.
//    - Never exceeds MaxOutstanding; assert no underflow.
//  - Back-to-back grants are allowed every cycle when capacity permits. Throughput is 1 fetch/cycle
//    when MaxOutstanding > RespLatency-1.
// CONFIGURATION
//  - IFR_STALL_EN defined: wait-state injection FSM with states IDLE and STALL.
//    - 16-bit Fibonacci LFSR, taps 16,14,13,11, steps every cycle.
//    - IDLE->STALL when instr_req_i & lfsr[3:0]==0; load stall counter with lfsr[5:4]+1 (1..4 cycles).
//    - STALL: stall=1, counter decrements; ->IDLE when it reaches 0.
//    - Responses already granted are unaffected.
//  - Undefined: no FSM and no LFSR; stall tied 0.
// STRUCTURE
//  - Shared package ifr_pkg:
//    - ifr_resp_t struct {logic valid; logic err; logic [31:0] rdata;}
//    - ifr_stall_e enum {IfrIdle, IfrStall}
//    - LFSR tap constant.
//  - Sub-module ifr_stall_gen (LFSR + FSM, outputs stall). It is instantiated only under IFR_STALL_EN.
//  - Pipeline and counter stay in the top.
// TESTING
//  1. Single fetch at 0x80, Lat=1, RAM[0x80]=0x0000_0013:
//     gnt and mem_req in cycle 0; rvalid in cycle 1 with rdata=0x13, err=0.
//  2. Lat=2, Max=1, req held for 0x80..0x8C:
//     gnt in cycles 0,2,4,6; rvalid in cycles 2,4,6,8; busy_o never drops mid-burst.
//  3. Lat=2, Max=2, same burst:
//     gnt every cycle 0..3; rvalid in cycles 2..5 with data in address order.
//  4. Fetch 0x0020_0000 (SizeBytes 2MB) and fetch 0x82:
//     each gets gnt with mem_req=0, then rvalid with err=1, rdata=0.
//  5. Two fetches outstanding, then rst_sys_ni low for 1 cycle:
//     no rvalid after release; cnt=0; busy_o=0; the next fetch behaves as test 1.
//  6. IFR_STALL_EN, 1000 random fetches:
//     gnt never high in STALL; rvalid count = gnt count; order preserved; stall length within 1..4.

Source files
------------

// File: rtl/ifr_pkg.sv
// ifr_pkg: shared types and constants for the instruction-fetch responder.
//   ifr_resp_t  - one response pipeline entry {valid, err, rdata}
//   ifr_stall_e - wait-state injector FSM states
//   IfrLfsrTaps - 16-bit Fibonacci LFSR tap mask (taps 16,14,13,11)
package ifr_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } ifr_resp_t;

  typedef enum logic {
    IfrIdle,
    IfrStall
  } ifr_stall_e;

  // Bits 15,13,12,10 of a left-shifting register correspond to taps 16,14,13,11.
  localparam logic [15:0] IfrLfsrTaps = 16'hB400;

endpackage

// File: rtl/ifr_stall_gen.sv
// ifr_stall_gen: pseudo-random wait-state injector for the fetch responder.
// Only present when the build defines IFR_STALL_EN; the top ties stall low otherwise.
// Ports:
//   clk_sys_i    in  1  system clock
//   rst_sys_ni   in  1  async reset, active low
//   instr_req_i  in  1  core fetch request (a stall only starts while a request is pending)
//   stall_o      out 1  registered; high for 1..4 cycles per stall episode
`ifdef IFR_STALL_EN
module ifr_stall_gen
  import ifr_pkg::*;
#(
  parameter logic [15:0] StallSeed = 16'hACE1
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic instr_req_i,
  output logic stall_o
);

  logic [15:0] lfsr_q;
  logic [2:0]  cnt_q;
  ifr_stall_e  state_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      lfsr_q  <= StallSeed;
      cnt_q   <= '0;
      state_q <= IfrIdle;
      stall_o <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & IfrLfsrTaps)};
      unique case (state_q)
        IfrIdle: begin
          if (instr_req_i && (lfsr_q[3:0] == 4'h0)) begin
            state_q <= IfrStall;
            cnt_q   <= {1'b0, lfsr_q[5:4]} + 3'd1;
            stall_o <= 1'b1;
          end
        end
        IfrStall: begin
          cnt_q <= cnt_q - 3'd1;
          // Leaving on the last count keeps stall_o high for exactly the loaded length.
          if (cnt_q == 3'd1) begin
            state_q <= IfrIdle;
            stall_o <= 1'b0;
          end
        end
        default: begin
          state_q <= IfrIdle;
          stall_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: memory-side responder for the Ibex instruction-fetch
// req/gnt/rvalid interface. Grants fetches under an outstanding limit, drives the
// read-only RAM port, and returns rdata/err in order RespLatency cycles after grant.
// Misaligned or out-of-window fetches get a bus error and never touch the RAM.
// Optional feature: define IFR_STALL_EN to insert random wait states (ifr_stall_gen).
// Ports:
//   clk_sys_i, rst_sys_ni            clock, async active-low reset
//   instr_req_i, instr_addr_i        core fetch request / byte address
//   instr_gnt_o                      request accepted this cycle (combinational)
//   instr_rvalid_o, instr_rdata_o,
//   instr_err_o                      in-order response; rdata 0 on error
//   mem_req_o, mem_addr_o            RAM read-port request / byte address
//   mem_rdata_i                      RAM data, valid the cycle after mem_req_o
//   busy_o                           fetches outstanding
module instr_fetch_responder
  import ifr_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned SizeBytes      = 2 * 1024 * 1024,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [15:0] StallSeed      = 16'hACE1
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [31:0]     WinMask = ~(SizeBytes - 32'd1);

  if (RespLatency < 1) begin : g_bad_latency
    $error("RespLatency must be at least 1");
  end
  if ((MaxOutstanding < 1) || (MaxOutstanding > RespLatency + 1)) begin : g_bad_max
    $error("MaxOutstanding must be in 1..RespLatency+1");
  end
  if ((SizeBytes == 0) || ((SizeBytes & (SizeBytes - 1)) != 0)) begin : g_bad_size
    $error("SizeBytes must be a power of 2");
  end
  if (StallSeed == 16'h0) begin : g_bad_seed
    $error("StallSeed must be nonzero");
  end

  logic            stall;
  logic            gnt;
  logic            err_dec;
  logic            s1_valid_q, s1_err_q;
  ifr_resp_t       resp;
  logic [CntW-1:0] cnt_q, cnt_d;

`ifdef IFR_STALL_EN
  ifr_stall_gen #(
    .StallSeed(StallSeed)
  ) u_stall_gen (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .instr_req_i(instr_req_i),
    .stall_o    (stall)
  );
`else
  assign stall = 1'b0;
`endif

  assign err_dec = (instr_addr_i[1:0] != 2'b00) || ((instr_addr_i & WinMask) != BaseAddr);

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign gnt = instr_req_i && !stall && ((cnt_q < CntMax) || resp.valid);

  assign instr_gnt_o = gnt;
  assign mem_req_o   = gnt && !err_dec;
  assign mem_addr_o  = instr_addr_i;

  // Entry 1: {valid, err} captured at grant; RAM data is not yet available.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= gnt;
      s1_err_q   <= gnt && err_dec;
    end
  end

  if (RespLatency == 1) begin : g_lat1
    // RAM output is already aligned with entry 1, so no data flop is needed.
    always_comb begin
      resp.valid = s1_valid_q;
      resp.err   = s1_err_q;
      resp.rdata = (s1_valid_q && !s1_err_q) ? mem_rdata_i : '0;
    end
  end else begin : g_latn
    // pipe_q[k] is pipeline entry k+2; RAM data joins at entry 2.
    ifr_resp_t pipe_q [RespLatency-1];

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
        for (int unsigned i = 0; i < RespLatency - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0].valid <= s1_valid_q;
        pipe_q[0].err   <= s1_err_q;
        pipe_q[0].rdata <= (s1_valid_q && !s1_err_q) ? mem_rdata_i : '0;
        for (int unsigned i = 1; i < RespLatency - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign resp = pipe_q[RespLatency-2];
  end

  assign instr_rvalid_o = resp.valid;
  assign instr_err_o    = resp.err;
  assign instr_rdata_o  = resp.rdata;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !resp.valid) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!gnt && resp.valid) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

  a_no_underflow: assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
    resp.valid |-> (cnt_q != '0));
  a_no_overflow: assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
    cnt_q <= CntMax);

endmodule
